// File: rtl/cache_line_word_mux_if.sv
// Line-capture / word-stream bus for cache_line_word_mux.
// The master drives the line and consumes words; the slave is the word sequencer.
interface cache_line_word_mux_if #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4,
    parameter int SEL_W = 2
);
    logic [WIDTH*WORDS-1:0] line_in;
    logic                   line_valid;
    logic                   line_ready;
    logic [SEL_W-1:0]       start_word;
    logic [WIDTH-1:0]       word_out;
    logic                   word_valid;
    logic                   word_ready;
    logic [SEL_W-1:0]       word_idx;
    logic                   word_last;
    logic                   busy;

    modport master (
        output line_in, line_valid, start_word, word_ready,
        input  line_ready, word_out, word_valid, word_idx, word_last, busy
    );

    modport slave (
        input  line_in, line_valid, start_word, word_ready,
        output line_ready, word_out, word_valid, word_idx, word_last, busy
    );
endinterface

// File: rtl/cache_line_word_mux.sv
// Captures a cache line and streams it critical-word-first, one word per beat.
// Optional macro CACHE_MUX_BACK2BACK_EN: accept the next line on the final beat (no bubble).
module cache_line_word_mux #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4,
    parameter int SEL_W = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    cache_line_word_mux_if.slave bus
);

    // state  | meaning
    // IDLE   | waiting for a line, line_ready high
    // STREAM | emitting words of the captured line, idx wraps modulo WORDS

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH*WORDS-1:0] line_q, line_d;
    logic [SEL_W-1:0]       idx_q, idx_d;
    logic [SEL_W-1:0]       cnt_q, cnt_d;
    logic                   last_beat;
    logic                   line_take;

    assign last_beat = (state_q == STREAM) && (cnt_q == SEL_W'(WORDS - 1));

`ifdef CACHE_MUX_BACK2BACK_EN
    assign bus.line_ready = (state_q == IDLE) || (last_beat && bus.word_ready);
`else
    assign bus.line_ready = (state_q == IDLE);
`endif

    assign line_take = bus.line_valid && bus.line_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (line_take) begin
                    state_d = STREAM;
                    line_d  = bus.line_in;
                    idx_d   = bus.start_word;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (bus.word_ready) begin
                    if (last_beat) begin
                        // line_take can only be true here in the back-to-back build
                        if (line_take) begin
                            state_d = STREAM;
                            line_d  = bus.line_in;
                            idx_d   = bus.start_word;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                        cnt_d = cnt_q + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a pure function of registered state.
    assign bus.word_out   = line_q[32'(idx_q) * WIDTH +: WIDTH];
    assign bus.word_idx   = idx_q;
    assign bus.word_valid = (state_q == STREAM);
    assign bus.word_last  = last_beat;
    assign bus.busy       = (state_q == STREAM);

endmodule

// File: tb/tb_cache_line_word_mux.sv
// Directed self-checking bench for cache_line_word_mux (WIDTH=32, WORDS=4).
module tb_cache_line_word_mux;
    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int SEL_W = 2;

    localparam logic [127:0] LINE_A = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] LINE_B = {32'h88, 32'h77, 32'h66, 32'h55};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    cache_line_word_mux_if #(.WIDTH(WIDTH), .WORDS(WORDS), .SEL_W(SEL_W)) bus ();

    cache_line_word_mux #(.WIDTH(WIDTH), .WORDS(WORDS), .SEL_W(SEL_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " line_ready"}, 32'(bus.line_ready), 32'd1);
        check({tag, " word_valid"}, 32'(bus.word_valid), 32'd0);
        check({tag, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic check_beat(input string tag, input logic [31:0] w, input logic [1:0] idx,
                              input logic last);
        check({tag, " word_valid"}, 32'(bus.word_valid), 32'd1);
        check({tag, " busy"}, 32'(bus.busy), 32'd1);
        check({tag, " word_out"}, bus.word_out, w);
        check({tag, " word_idx"}, 32'(bus.word_idx), 32'(idx));
        check({tag, " word_last"}, 32'(bus.word_last), 32'(last));
    endtask

    // One full line with word_ready held high; optionally pulses line_valid mid-burst.
    task automatic run_line(input string tag, input logic [127:0] line, input logic [1:0] sw,
                            input logic [31:0] ew[4], input logic [1:0] ei[4], input bit inject);
        bus.line_in    = line;
        bus.start_word = sw;
        bus.line_valid = 1'b1;
        bus.word_ready = 1'b1;
        tick();
        bus.line_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_beat($sformatf("%s beat%0d", tag, k), ew[k], ei[k], k == 3);
            if (k < 3) check($sformatf("%s beat%0d line_ready", tag, k), 32'(bus.line_ready), 32'd0);
            if (inject && k == 1) begin
                bus.line_valid = 1'b1;
                bus.line_in    = LINE_B;
                bus.start_word = 2'd2;
            end
            if (inject && k == 2) bus.line_valid = 1'b0;
            tick();
        end
        check_idle({tag, " end"});
    endtask

    logic [31:0] exp_w[10];
    logic        exp_v[10];
    bit          take;

    initial begin
        bus.line_in    = '0;
        bus.line_valid = 1'b0;
        bus.start_word = '0;
        bus.word_ready = 1'b0;

        // Reset held for 3 cycles, then idle
        rst_n = 1'b0;
        repeat (3) tick();
        check_idle("in_reset");
        check("in_reset word_out", bus.word_out, 32'h0);
        rst_n = 1'b1;
        tick();
        check_idle("after_reset");
        check("after_reset word_out", bus.word_out, 32'h0);
        check("after_reset word_last", 32'(bus.word_last), 32'd0);

        // Linear stream, with a line_valid pulse mid-burst that must be ignored
        run_line("linear", LINE_A, 2'd0, '{32'h11, 32'h22, 32'h33, 32'h44},
                 '{2'd0, 2'd1, 2'd2, 2'd3}, 1'b1);

        // Critical-word-first wrap
        run_line("wrap", LINE_A, 2'd3, '{32'h44, 32'h11, 32'h22, 32'h33},
                 '{2'd3, 2'd0, 2'd1, 2'd2}, 1'b0);

        // Back-pressure: first beat held for 5 cycles
        bus.line_in    = LINE_A;
        bus.start_word = 2'd1;
        bus.line_valid = 1'b1;
        bus.word_ready = 1'b0;
        tick();
        bus.line_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_beat($sformatf("bp hold%0d", k), 32'h22, 2'd1, 1'b0);
            tick();
        end
        bus.word_ready = 1'b1;
        check_beat("bp beat0", 32'h22, 2'd1, 1'b0);
        tick();
        check_beat("bp beat1", 32'h33, 2'd2, 1'b0);
        tick();
        check_beat("bp beat2", 32'h44, 2'd3, 1'b0);
        tick();
        check_beat("bp beat3", 32'h11, 2'd0, 1'b1);
        tick();
        check_idle("bp end");

        // Reset asserted after the second beat is taken
        bus.line_in    = LINE_A;
        bus.start_word = 2'd0;
        bus.line_valid = 1'b1;
        tick();
        bus.line_valid = 1'b0;
        check_beat("rst beat0", 32'h11, 2'd0, 1'b0);
        tick();
        check_beat("rst beat1", 32'h22, 2'd1, 1'b0);
        tick();
        check_beat("rst beat2", 32'h33, 2'd2, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_idle("rst async");
        check("rst async word_out", bus.word_out, 32'h0);
        check("rst async word_idx", 32'(bus.word_idx), 32'd0);
        check("rst async word_last", 32'(bus.word_last), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst after%0d word_valid", k), 32'(bus.word_valid), 32'd0);
        end

        // Two lines offered back to back, start_word=2
`ifdef CACHE_MUX_BACK2BACK_EN
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_w = '{32'h33, 32'h44, 32'h11, 32'h22, 32'h77, 32'h88, 32'h55, 32'h66, 32'h0, 32'h0};
`else
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_w = '{32'h33, 32'h44, 32'h11, 32'h22, 32'h0, 32'h77, 32'h88, 32'h55, 32'h66, 32'h0};
`endif
        bus.line_in    = LINE_A;
        bus.start_word = 2'd2;
        bus.line_valid = 1'b1;
        bus.word_ready = 1'b1;
        tick();
        bus.line_in = LINE_B;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("b2b cyc%0d word_valid", k), 32'(bus.word_valid), 32'(exp_v[k]));
            if (exp_v[k]) check($sformatf("b2b cyc%0d word_out", k), bus.word_out, exp_w[k]);
            take = bus.line_ready && bus.line_valid;
            tick();
            if (take) bus.line_valid = 1'b0;
        end
        check_idle("b2b end");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/cache_line_word_mux.md
Name: cache_line_word_mux

Overview:
Registered, parametrised word selector for cache line read-out.
- Captures a full cache line in one handshake, then streams its words out one per beat over a valid/ready interface.
- Streaming is critical-word-first: starts at a requested word offset and wraps modulo the line length.
- Sits between the cache data array and the CPU/refill response path. It replaces ad-hoc word muxing with a back-pressurable sequencer.

Parameters:
WIDTH, 32, bits per word.
WORDS, 4, words per cache line; power of 2, >= 2.
SEL_W, 2, word-index width; must equal log2(WORDS).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
line_in  input  WIDTH*WORDS  cache line; word k occupies bits [k*WIDTH +: WIDTH].
line_valid  input  1  line_in/start_word valid.
line_ready  output  1  block can accept a line.
start_word  input  SEL_W  first word offset (critical word).
word_out  output  WIDTH  current word.
word_valid  output  1  word_out valid.
word_ready  input  1  consumer accepts word_out.
word_idx  output  SEL_W  line offset of word_out.
word_last  output  1  current beat is the final word of the line.
busy  output  1  a line is being streamed.

Behaviour:
Interface rule (decided): one clock, clk; reset rst_n, asynchronous, active-low.

Reset values:
- state IDLE; line register cleared to 0.
- word_out=0, word_idx=0, word_valid=0, word_last=0, busy=0.
- line_ready=1.

States:
- IDLE: line_ready=1, word_valid=0, busy=0.
- STREAM: line_ready=0 (except as in Optional Feature), word_valid=1, busy=1.

Transitions:
- IDLE -> STREAM on line_valid&&line_ready: register line_in, idx=start_word, beat count=0.
- STREAM, word_valid&&word_ready: idx=(idx+1) mod WORDS via natural SEL_W overflow; count+1.
- Handshake while word_last=1: -> IDLE.

Outputs:
- word_out = registered line word [idx]; word_idx = idx; word_last = (count==WORDS-1).
- All outputs derive from registers only; no combinational path from line_in/line_valid/start_word to outputs.

Latency: first word valid the cycle after the line handshake; one word per cycle with word_ready held high; WORDS beats per line.

Boundary conditions:
- Back-pressure: while word_valid && !word_ready, word_out, word_idx and word_last hold stable.
- Wrap: start_word=WORDS-1 yields order WORDS-1, 0, 1, ..., WORDS-2.
- start_word=0 gives linear order.
- line_valid asserted while in STREAM (feature off): ignored; the line is not captured.
- rst_n low mid-burst: burst abandoned immediately (async); all outputs return to reset values; no resume.

Optional Feature:
Macro: CACHE_MUX_BACK2BACK_EN.
- Defined: line_ready also =1 during a STREAM beat where word_last && word_ready (combinational from word_ready). A line accepted that cycle loads directly into STREAM with the new start_word, giving zero bubble between lines.
- Undefined: one IDLE cycle between consecutive lines (line_ready only in IDLE); minimum WORDS+1 cycles per line.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> line_ready=1, word_valid=0, busy=0, word_out=0.
- Linear stream: WORDS=4, line words {D3..D0}={44,33,22,11}, start_word=0, word_ready=1 -> 11,22,33,44 on consecutive cycles, word_idx 0,1,2,3, word_last only on 44, then line_ready=1.
- Critical-word-first wrap: same line, start_word=3 -> words 44,11,22,33, word_idx 3,0,1,2, word_last on 33.
- Back-pressure: start_word=1, word_ready low 5 cycles after first beat -> word_out=22, word_idx=1 held stable all 5 cycles; stream completes after word_ready=1.
- Mid-burst reset: assert rst_n low after second beat -> word_valid=0 and busy=0 immediately; after release no stale words are emitted.
- Back-to-back: two lines offered continuously with start_word=2 -> with CACHE_MUX_BACK2BACK_EN, 8 consecutive valid beats; without it, exactly one word_valid=0 gap between lines.
